// File: rtl/sdram_ctrl_refseq_pkg.sv
// sdram_ctrl_refseq_pkg
//   Shared definitions for the SDRAM controller slice. It holds the SDRAM
//   command encodings ({cs_n, ras_n, cas_n, we_n}) and the delay-counter
//   width. The access engine uses the same encodings.
package sdram_ctrl_refseq_pkg;

  // Width of the shared wait-state down-counter.
  localparam int DLY_W = 14;

  typedef logic [3:0] sdram_cmd_t;

  localparam sdram_cmd_t CMD_NOP  = 4'b0111;
  localparam sdram_cmd_t CMD_PALL = 4'b0010;
  localparam sdram_cmd_t CMD_AREF = 4'b0001;
  localparam sdram_cmd_t CMD_MRS  = 4'b0000;

  // PRECHARGE ALL is selected by A10 high.
  localparam logic [11:0] ADDR_PALL = 12'h400;

endpackage

// File: rtl/sdram_ctrl_dly.sv
// sdram_ctrl_dly
//   Loadable down-counter with a zero flag. It holds at zero until it is
//   loaded again. Reset loads RST_VAL so that a wait can start straight
//   out of reset.
// Ports:
//   clk      - clock
//   rst      - synchronous active-high reset (loads RST_VAL)
//   load     - load load_val this edge (has priority over the count)
//   load_val - value to load
//   zero     - counter currently reads zero
module sdram_ctrl_dly #(
  parameter int           W       = 14,
  parameter logic [W-1:0] RST_VAL = {W{1'b0}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_r;

  // Count register: load, otherwise decrement until it reaches zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= RST_VAL;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != {W{1'b0}}) begin
      cnt_r <= cnt_r - ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {W{1'b0}});

endmodule

// File: rtl/sdram_ctrl_refseq.sv
// sdram_ctrl_refseq
//   SDRAM power-up init and refresh command sequencer. After reset it waits
//   INIT_CYCLES, then issues PALL, INIT_REFS x AREF and MRS, and then raises
//   init_done. After that, a refresh request (ref_req) that is granted while
//   the access engine is idle (bus_idle) produces PALL followed by AREF,
//   with tRP and tRFC respected.
// Ports:
//   clk        - sole clock
//   rst        - synchronous active-high reset
//   ref_req    - refresh request level from the refresh timer (the timer's
//                "ref"; renamed because ref is a reserved word)
//   bus_idle   - access engine idle and preemptable; sampled only in IDLE
//   refreshing - refresh sequence in progress (ack to timer/access engine)
//   init_done  - init complete; stays set until reset
//   cmd_own    - this block drives the SDRAM command/address bus
//   cmd        - {cs_n, ras_n, cas_n, we_n}
//   addr       - SDRAM address bus
//   ba         - bank address
// All outputs are registered and are derived from the next state.
module sdram_ctrl_refseq
  import sdram_ctrl_refseq_pkg::*;
#(
  parameter int          INIT_CYCLES = 10000,
  parameter int          INIT_REFS   = 2,
  parameter int          T_RP        = 2,
  parameter int          T_RFC       = 7,
  parameter int          T_MRD       = 2,
  parameter logic [11:0] MODE_REG    = 12'h022
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ref_req,
  input  logic        bus_idle,
  output logic        refreshing,
  output logic        init_done,
  output logic        cmd_own,
  output logic [3:0]  cmd,
  output logic [11:0] addr,
  output logic [1:0]  ba
);

  // A wait of N cycles loads N-1. The load happens on entry to the command
  // state, so the command cycle itself counts toward the delay.
  localparam logic [DLY_W-1:0] LD_INIT = DLY_W'(INIT_CYCLES - 1);
  localparam logic [DLY_W-1:0] LD_RP   = DLY_W'(T_RP - 1);
  localparam logic [DLY_W-1:0] LD_RFC  = DLY_W'(T_RFC - 1);
  localparam logic [DLY_W-1:0] LD_MRD  = DLY_W'(T_MRD - 1);
  localparam logic [3:0]       REFS_L  = 4'(INIT_REFS);

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT_PALL = 4'd1,
    S_INIT_TRP  = 4'd2,
    S_INIT_REF  = 4'd3,
    S_INIT_TRFC = 4'd4,
    S_INIT_MRS  = 4'd5,
    S_INIT_TMRD = 4'd6,
    S_IDLE      = 4'd7,
    S_PALL      = 4'd8,
    S_TRP       = 4'd9,
    S_AREF      = 4'd10,
    S_TRFC      = 4'd11
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [3:0]       ref_cnt_r;
  logic             more_refs_s;
  logic             dly_load_s;
  logic [DLY_W-1:0] dly_val_s;
  logic             dly_zero_s;

  // ref_cnt_r counts the init AREFs issued so far, including the one in progress.
  assign more_refs_s = (ref_cnt_r < REFS_L);

  sdram_ctrl_dly #(
    .W       (DLY_W),
    .RST_VAL (LD_INIT)
  ) u_dly (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load_s),
    .load_val (dly_val_s),
    .zero     (dly_zero_s)
  );

  // Next-state decode and delay-counter load control.
  // A command state exits directly when its delay is a single cycle.
  always_comb begin
    state_nxt_s = state_r;
    dly_load_s  = 1'b0;
    dly_val_s   = {DLY_W{1'b0}};
    case (state_r)
      S_INIT_WAIT: begin
        if (dly_zero_s) begin
          state_nxt_s = S_INIT_PALL;
          dly_load_s  = 1'b1;
          dly_val_s   = LD_RP;
        end else begin
          state_nxt_s = S_INIT_WAIT;
        end
      end
      S_INIT_PALL, S_INIT_TRP: begin
        if (dly_zero_s) begin
          state_nxt_s = S_INIT_REF;
          dly_load_s  = 1'b1;
          dly_val_s   = LD_RFC;
        end else begin
          state_nxt_s = S_INIT_TRP;
        end
      end
      S_INIT_REF, S_INIT_TRFC: begin
        if (dly_zero_s) begin
          dly_load_s = 1'b1;
          if (more_refs_s) begin
            state_nxt_s = S_INIT_REF;
            dly_val_s   = LD_RFC;
          end else begin
            state_nxt_s = S_INIT_MRS;
            dly_val_s   = LD_MRD;
          end
        end else begin
          state_nxt_s = S_INIT_TRFC;
        end
      end
      S_INIT_MRS, S_INIT_TMRD: begin
        if (dly_zero_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_INIT_TMRD;
        end
      end
      S_IDLE: begin
        if (ref_req && bus_idle) begin
          state_nxt_s = S_PALL;
          dly_load_s  = 1'b1;
          dly_val_s   = LD_RP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_PALL, S_TRP: begin
        if (dly_zero_s) begin
          state_nxt_s = S_AREF;
          dly_load_s  = 1'b1;
          dly_val_s   = LD_RFC;
        end else begin
          state_nxt_s = S_TRP;
        end
      end
      S_AREF, S_TRFC: begin
        if (dly_zero_s) begin
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_TRFC;
        end
      end
      default: begin
        state_nxt_s = S_INIT_WAIT;
        dly_load_s  = 1'b1;
        dly_val_s   = LD_INIT;
      end
    endcase
  end

  // State register and registered command/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= S_INIT_WAIT;
      ref_cnt_r  <= 4'd0;
      cmd        <= CMD_NOP;
      addr       <= 12'h000;
      ba         <= 2'b00;
      refreshing <= 1'b0;
      init_done  <= 1'b0;
      cmd_own    <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      ref_cnt_r  <= (state_nxt_s == S_INIT_REF) ? (ref_cnt_r + 4'd1) : ref_cnt_r;
      cmd_own    <= (state_nxt_s != S_IDLE);
      refreshing <= (state_nxt_s inside {S_PALL, S_TRP, S_AREF, S_TRFC});
      // IDLE is reachable only through the end of init.
      init_done  <= init_done | (state_nxt_s == S_IDLE);
      ba         <= 2'b00;
      case (state_nxt_s)
        S_INIT_PALL, S_PALL: begin
          cmd  <= CMD_PALL;
          addr <= ADDR_PALL;
        end
        S_INIT_REF, S_AREF: begin
          cmd  <= CMD_AREF;
          addr <= 12'h000;
        end
        S_INIT_MRS: begin
          cmd  <= CMD_MRS;
          addr <= MODE_REG;
        end
        default: begin
          cmd  <= CMD_NOP;
          addr <= 12'h000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_ctrl_refseq.sv
// tb_sdram_ctrl_refseq
//   Self-checking bench for sdram_ctrl_refseq. Expected outputs for every
//   cycle come from a timeline model. That model works from the cycle of the
//   last reset and from the cycle in which the most recent refresh was
//   granted, and it computes command positions with plain arithmetic.
module tb_sdram_ctrl_refseq;

  localparam int IC       = 20;
  localparam int RP       = 2;
  localparam int RFC      = 7;
  localparam int MRD      = 2;
  localparam int NREF     = 2;
  localparam int MRS_AT   = IC + RP + NREF * RFC;   // 36
  localparam int INIT_END = MRS_AT + MRD;           // 38

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PALL = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_req = 1'b0;
  logic        bus_idle = 1'b0;
  logic        refreshing;
  logic        init_done;
  logic        cmd_own;
  logic [3:0]  cmd;
  logic [11:0] addr;
  logic [1:0]  ba;

  always #5 clk = ~clk;

  sdram_ctrl_refseq #(
    .INIT_CYCLES (IC),
    .INIT_REFS   (NREF),
    .T_RP        (RP),
    .T_RFC       (RFC),
    .T_MRD       (MRD),
    .MODE_REG    (12'h022)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ref_req    (ref_req),
    .bus_idle   (bus_idle),
    .refreshing (refreshing),
    .init_done  (init_done),
    .cmd_own    (cmd_own),
    .cmd        (cmd),
    .addr       (addr),
    .ba         (ba)
  );

  int n_vec = 0;
  int n_err = 0;
  int n = 0;             // edge count; cycle n follows edge n
  int t0 = 0;            // edge of the last sampled reset
  int rs = -1000;        // cycle in which the latest refresh PALL is due
  bit prev_idle = 1'b0;  // model: previous cycle was a post-init idle cycle

  logic [3:0]  e_cmd;
  logic [11:0] e_addr;
  logic        e_rf;
  logic        e_done;
  logic        e_own;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, n);
    end
  endtask

  // Advance one clock, update the model from the inputs sampled at that
  // edge, then compare every output #1 after the edge.
  task automatic step();
    int rel;
    bit in_rf;
    @(posedge clk);
    n++;
    if (rst) begin
      t0 = n;
      rs = -1000;
    end else if (prev_idle && ref_req && bus_idle) begin
      rs = n;
    end
    rel    = n - t0;
    e_cmd  = NOP;
    e_addr = 12'h000;
    if (rel < INIT_END) begin
      e_own  = 1'b1;
      e_rf   = 1'b0;
      e_done = 1'b0;
      if (rel == IC) begin
        e_cmd  = PALL;
        e_addr = 12'h400;
      end else if (rel == MRS_AT) begin
        e_cmd  = MRS;
        e_addr = 12'h022;
      end else if (rel >= IC + RP && rel < MRS_AT && ((rel - IC - RP) % RFC) == 0) begin
        e_cmd = AREF;
      end
    end else begin
      in_rf  = (n >= rs) && (n < rs + RP + RFC);
      e_own  = in_rf;
      e_rf   = in_rf;
      e_done = 1'b1;
      if (n == rs) begin
        e_cmd  = PALL;
        e_addr = 12'h400;
      end else if (n == rs + RP) begin
        e_cmd = AREF;
      end
    end
    prev_idle = e_done && !e_rf;
    #1;
    chk("cmd",        {12'h000, cmd},         {12'h000, e_cmd});
    chk("addr",       {4'h0, addr},           {4'h0, e_addr});
    chk("ba",         {14'h0000, ba},         16'h0000);
    chk("refreshing", {15'h0000, refreshing}, {15'h0000, e_rf});
    chk("init_done",  {15'h0000, init_done},  {15'h0000, e_done});
    chk("cmd_own",    {15'h0000, cmd_own},    {15'h0000, e_own});
  endtask

  initial begin
    int k;
    // Reset, then a plain init with no requests.
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    repeat (60) step();

    // Random traffic. The timer holds ref_req until it sees refreshing.
    // Rare resets are mixed in.
    for (int i = 0; i < 800; i++) begin
      if (!ref_req && $urandom_range(0, 19) == 0) ref_req = 1'b1;
      bus_idle = ($urandom_range(0, 2) != 0);
      rst      = ($urandom_range(0, 399) == 0);
      step();
      if (refreshing) ref_req = 1'b0;
    end
    rst     = 1'b0;
    ref_req = 1'b0;
    repeat (50) step();

    // Busy defer: 50 busy cycles with the request pending, then grant.
    ref_req  = 1'b1;
    bus_idle = 1'b0;
    repeat (50) step();
    bus_idle = 1'b1;
    k = 0;
    step();
    while (!refreshing && k < 20) begin
      k++;
      step();
    end
    chk("defer_grant_latency", 16'(k), 16'd0);
    ref_req = 1'b0;
    repeat (15) step();

    // Early request during init: served on the first idle cycle.
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (5) step();
    ref_req  = 1'b1;
    bus_idle = 1'b1;
    k = 0;
    step();
    while (!refreshing && k < 100) begin
      k++;
      step();
    end
    chk("early_ref_pall_cycle", 16'(n - t0), 16'(INIT_END + 1));
    ref_req = 1'b0;
    repeat (12) step();

    // Reset applied right after a refresh AREF.
    ref_req  = 1'b1;
    bus_idle = 1'b1;
    k = 0;
    step();
    while (!(refreshing && cmd == AREF) && k < 30) begin
      k++;
      step();
    end
    chk("mid_ref_aref_seen", {15'h0000, (k < 30)}, 16'h0001);
    rst     = 1'b1;
    ref_req = 1'b0;
    step();
    rst = 1'b0;
    repeat (45) step();

    // Withdrawn request: a 3-cycle pulse while the bus is busy.
    bus_idle = 1'b0;
    ref_req  = 1'b1;
    repeat (3) step();
    ref_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      bus_idle = 1'($urandom_range(0, 1));
      step();
      chk("withdrawn_no_cmd", {12'h000, cmd}, {12'h000, NOP});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sdram_ctrl_refseq.md
# sdram_ctrl_refseq

SDRAM power-up initialisation and refresh command sequencer for the i2d SoC SDRAM controller. It sits directly downstream of the refresh timer, which holds `ref` high until it sees `refreshing`. When the data-path access engine reports a safe point, the block takes the SDRAM command bus and issues PRECHARGE ALL followed by AUTO REFRESH, honouring tRP and tRFC. After reset it first runs the JEDEC init sequence (wait, PALL, N×AREF, MRS).

## Interface
Parameters:
- `INIT_CYCLES`, 10000: NOP cycles after reset before the first PALL (200 µs @ 50 MHz); range 1..16383.
- `INIT_REFS`, 2: AUTO REFRESH commands issued during init; range 1..15.
- `T_RP`, 2: cycles from PALL to the next command; ≥1.
- `T_RFC`, 7: cycles from AREF to the next command; ≥1.
- `T_MRD`, 2: cycles from MRS to `init_done`; ≥1.
- `MODE_REG`, 12'h022: value driven on `addr` with MRS (CAS 2, burst 4, sequential).

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `ref` in 1: refresh request level from the refresh timer.
- `bus_idle` in 1: access engine has no open row and no access in flight; may be preempted.
- `refreshing` out 1: a refresh sequence is in progress (acknowledge to the timer and the access engine).
- `init_done` out 1: init complete; sticky until reset.
- `cmd_own` out 1: this block drives the SDRAM command/address bus this cycle.
- `cmd` out 4: {cs_n, ras_n, cas_n, we_n}.
- `addr` out 12: SDRAM address bus.
- `ba` out 2: bank address.

## Operation
- Command encodings: NOP 4'b0111, PALL 4'b0010 (addr[10]=1), AREF 4'b0001, MRS 4'b0000 (addr=MODE_REG, ba=0). Every non-command cycle drives NOP, addr=0, ba=0.
- States: INIT_WAIT → INIT_PALL → INIT_TRP → INIT_REF → INIT_TRFC → (INIT_REF again while the ref counter < INIT_REFS, else INIT_MRS) → INIT_TMRD → IDLE → PALL → TRP → AREF → TRFC → IDLE.
- Delay counter: one 14-bit down-counter shared by all wait states. It loads (param−1) on entry to a wait state, and the state exits when the counter reads 0. Init refresh counter: 4 bits.
- `cmd_own`: 1 in every state except IDLE.
- `refreshing`: 1 in PALL, TRP, AREF and TRFC only, never during init.
- `init_done`: set on exit from INIT_TMRD; cleared only by `rst`.
- IDLE: if `ref & bus_idle`, go to PALL next cycle. If `ref` is high and `bus_idle` is low, wait in IDLE with no timeout. If `ref` falls before being granted, no refresh occurs.
- `ref` during init: ignored, not lost. The timer holds the level, so it is serviced on the first IDLE cycle.
- `bus_idle` is sampled only in IDLE. Once PALL is issued the sequence runs to completion regardless of `bus_idle` or `ref`.

## Timing
- Reset values: cmd=NOP, addr=0, ba=0, refreshing=0, init_done=0, cmd_own=1. State = INIT_WAIT with the counter loaded.
- Reset mid-sequence, in any state: abort on the next edge and restart INIT_WAIT with the full INIT_CYCLES wait.
- Init sequence, with cycle 0 = the first cycle after `rst` falls:
  - PALL at cycle INIT_CYCLES.
  - First AREF at +T_RP; each subsequent AREF at +T_RFC after the previous one.
  - MRS T_RFC after the last AREF.
  - `init_done`=1 T_MRD cycles after MRS.
- Refresh latency:
  - If `ref & bus_idle` is sampled high in IDLE at edge k, PALL and `refreshing`=1 are driven in cycle k+1.
  - AREF is driven at k+1+T_RP.
  - IDLE is re-entered at k+1+T_RP+T_RFC, where `refreshing`=0 and `cmd_own`=0.
- `refreshing` lasts exactly T_RP+T_RFC cycles.
- All outputs are registered; there are no combinational paths from input to output.

## Structure
- Command encodings (NOP/PALL/AREF/MRS) and default timing constants go in the shared `i2d_soc_defines.v`. The access engine uses the same encodings.
- State encoding is a localparam inside the module.
- One small sub-module is natural: `sdram_ctrl_dly`, the loadable 14-bit down-counter with a `zero` flag, reusable by the access engine.

## Test plan
Bench parameters: INIT_CYCLES=20, T_RP=2, T_RFC=7, T_MRD=2, INIT_REFS=2.

- Reset/init:
  - Stimulus: drop `rst` at cycle 0.
  - Required: NOP in cycles 0–19; PALL with addr[10]=1 at 20; AREF at 22 and 29; MRS with addr=12'h022 at 36; `init_done`=1 at 38; `refreshing`=0 throughout.
- Basic refresh:
  - Stimulus: after init, `ref`=1 and `bus_idle`=1 sampled at edge k.
  - Required: PALL at k+1; AREF at k+3; `refreshing` high for exactly 9 cycles; `cmd_own`=0 at k+10.
- Busy defer:
  - Stimulus: `ref`=1 with `bus_idle`=0 for 50 cycles, then `bus_idle`=1.
  - Required: no PALL during the busy cycles; PALL exactly 1 cycle after `bus_idle` rises.
- Early ref:
  - Stimulus: `ref`=1 from cycle 5, during init.
  - Required: the init sequence is unchanged; refresh PALL occurs on the cycle after `init_done` rises.
- Reset mid-refresh:
  - Stimulus: assert `rst` one cycle after AREF.
  - Required: next cycle cmd=NOP, `refreshing`=0, `init_done`=0; the full 20-cycle init wait restarts.
- Withdrawn request:
  - Stimulus: `ref` pulses high for 3 cycles while `bus_idle`=0.
  - Required: no PALL or AREF issued; the block stays in IDLE.
